// File: rtl/board_check_seq_if.sv
// Handshake and board-RAM read bus between the main FSM/RAM side (master) and the check sequencer (slave).
interface board_check_seq_if #(
  parameter int ADDR_W = 7,
  parameter int VAL_W  = 4
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [VAL_W-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              valid;
  logic              solved;
  logic [1:0]        err_group;
  logic [3:0]        err_index;

  modport master (
    output start, rd_data,
    input  rd_en, rd_addr, busy, done, valid, solved, err_group, err_index
  );

  modport slave (
    input  start, rd_data,
    output rd_en, rd_addr, busy, done, valid, solved, err_group, err_index
  );
endinterface

// File: rtl/board_check_seq.sv
// Sudoku board checker: scans rows, columns, then boxes (one read per cycle) and reports valid/solved.
// Optional BOARD_CHECK_EARLY_EXIT_EN: stop scanning and finish on the first conflict.
module board_check_seq #(
  parameter int N      = 9,
  parameter int BOX    = 3,
  parameter int ADDR_W = 7,
  parameter int VAL_W  = 4
) (
  input  logic             clka,
  input  logic             restart,
  board_check_seq_if.slave bus
);

  localparam logic [3:0] LAST  = 4'(N - 1);
  localparam logic [3:0] BSTEP = 4'(BOX);
  localparam logic [3:0] BMAX  = 4'(N - BOX);
  localparam logic [1:0] BLAST = 2'(BOX - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ROWS, ST_COLS, ST_BOXES, ST_FINISH} state_t;

  state_t            state_q, state_d;
  logic [3:0]        g_q, g_d, e_q, e_d;
  logic [3:0]        row_q, row_d, col_q, col_d;
  logic [3:0]        br_q, br_d, bc_q, bc_d;
  logic [1:0]        er_q, er_d, ec_q, ec_d;
  logic [N-1:0]      mask_q, mask_d;
  logic              blank_q, blank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d, solved_q, solved_d;
  logic [1:0]        err_group_q, err_group_d;
  logic [3:0]        err_index_q, err_index_d;

  logic              scanning, is_blank, illegal, conflict, grp_end;
  logic [N-1:0]      mask_base, bit_v;
  logic [1:0]        grp_code;

  // The state register doubles as the phase tag of the read currently in flight.
  always_comb begin
    scanning  = (state_q == ST_ROWS) || (state_q == ST_COLS) || (state_q == ST_BOXES);
    grp_end   = (e_q == LAST);
    mask_base = (e_q == 4'd0) ? '0 : mask_q;
    is_blank  = (bus.rd_data == '0);
    illegal   = (bus.rd_data > VAL_W'(N));
    bit_v     = is_blank ? '0 : (N'(1) << (bus.rd_data - VAL_W'(1)));
    conflict  = scanning && (illegal || (|(mask_base & bit_v)));
    case (state_q)
      ST_ROWS:  grp_code = 2'b01;
      ST_COLS:  grp_code = 2'b10;
      ST_BOXES: grp_code = 2'b11;
      default:  grp_code = 2'b00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    e_d         = e_q;
    row_d       = row_q;
    col_d       = col_q;
    br_d        = br_q;
    bc_d        = bc_q;
    er_d        = er_q;
    ec_d        = ec_q;
    mask_d      = mask_q;
    blank_d     = blank_q;
    rd_addr_d   = rd_addr_q;
    valid_d     = valid_q;
    solved_d    = solved_q;
    err_group_d = err_group_q;
    err_index_d = err_index_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_ROWS;
          g_d         = '0;
          e_d         = '0;
          row_d       = '0;
          col_d       = '0;
          br_d        = '0;
          bc_d        = '0;
          er_d        = '0;
          ec_d        = '0;
          mask_d      = '0;
          blank_d     = 1'b0;
          rd_addr_d   = '0;
          valid_d     = 1'b0;
          solved_d    = 1'b0;
          err_group_d = 2'b00;
          err_index_d = 4'd0;
        end
      end

      ST_ROWS, ST_COLS, ST_BOXES: begin
        mask_d  = mask_base | bit_v;
        blank_d = blank_q | is_blank;
        if (conflict && (err_group_q == 2'b00)) begin
          err_group_d = grp_code;
          err_index_d = g_q;
        end
        e_d = grp_end ? 4'd0 : e_q + 4'd1;
        if (grp_end) g_d = (g_q == LAST) ? 4'd0 : g_q + 4'd1;

        case (state_q)
          ST_ROWS: begin
            if (grp_end) begin
              row_d = row_q + 4'd1;
              col_d = '0;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
          ST_COLS: begin
            if (grp_end) begin
              row_d = '0;
              col_d = col_q + 4'd1;
            end else begin
              row_d = row_q + 4'd1;
            end
          end
          default: begin
            // Box walk: column within box, then row within box, then next box origin.
            if (ec_q != BLAST) begin
              col_d = col_q + 4'd1;
              ec_d  = ec_q + 2'd1;
            end else if (er_q != BLAST) begin
              col_d = bc_q;
              row_d = row_q + 4'd1;
              ec_d  = '0;
              er_d  = er_q + 2'd1;
            end else begin
              ec_d = '0;
              er_d = '0;
              if (bc_q == BMAX) begin
                bc_d = '0;
                br_d = br_q + BSTEP;
              end else begin
                bc_d = bc_q + BSTEP;
              end
              row_d = br_d;
              col_d = bc_d;
            end
          end
        endcase

        if (grp_end && (g_q == LAST)) begin
          row_d = '0;
          col_d = '0;
          br_d  = '0;
          bc_d  = '0;
          er_d  = '0;
          ec_d  = '0;
          case (state_q)
            ST_ROWS: state_d = ST_COLS;
            ST_COLS: state_d = ST_BOXES;
            default: state_d = ST_FINISH;
          endcase
        end

`ifdef BOARD_CHECK_EARLY_EXIT_EN
        if (conflict) state_d = ST_FINISH;
`endif

        if (state_d == ST_FINISH) begin
          valid_d  = !(conflict || (err_group_q != 2'b00));
          solved_d = valid_d && !blank_d;
        end else begin
          rd_addr_d = ADDR_W'(row_d) * ADDR_W'(N) + ADDR_W'(col_d);
        end
      end

      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!restart) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      e_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      br_q        <= '0;
      bc_q        <= '0;
      er_q        <= '0;
      ec_q        <= '0;
      mask_q      <= '0;
      blank_q     <= 1'b0;
      rd_addr_q   <= '0;
      valid_q     <= 1'b0;
      solved_q    <= 1'b0;
      err_group_q <= 2'b00;
      err_index_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      e_q         <= e_d;
      row_q       <= row_d;
      col_q       <= col_d;
      br_q        <= br_d;
      bc_q        <= bc_d;
      er_q        <= er_d;
      ec_q        <= ec_d;
      mask_q      <= mask_d;
      blank_q     <= blank_d;
      rd_addr_q   <= rd_addr_d;
      valid_q     <= valid_d;
      solved_q    <= solved_d;
      err_group_q <= err_group_d;
      err_index_q <= err_index_d;
    end
  end

  assign bus.rd_en     = scanning;
  assign bus.busy      = scanning;
  assign bus.done      = (state_q == ST_FINISH);
  assign bus.rd_addr   = rd_addr_q;
  assign bus.valid     = valid_q;
  assign bus.solved    = solved_q;
  assign bus.err_group = err_group_q;
  assign bus.err_index = err_index_q;

endmodule

// File: doc/board_check_seq.md
Name: board_check_seq

Overview:
Sequencer that verifies the Sudoku board after the main FSM reaches the checking state. On a start pulse it scans board memory through a single synchronous read port, one read per cycle. It walks all 9 rows, then all 9 columns, then all 9 boxes, and reports valid (no duplicate digits) and solved (valid with no blanks). Sits between the main FSM (start from check_flag, solved back to the FSM) and the board RAM in the datapath.

Parameters:
N, 9, board side / group size
BOX, 3, box side (N = BOX*BOX)
ADDR_W, 7, board RAM address width (N*N = 81 cells)
VAL_W, 4, cell value width; 0 = blank, 1..9 = digit

Ports:
clka  input  1  single system clock, all logic on rising edge
restart  input  1  synchronous reset, active-low
start  input  1  begin scan; sampled only in IDLE
rd_en  output  1  board RAM read enable
rd_addr  output  ADDR_W  read address = row*N + col
rd_data  input  VAL_W  RAM data; valid at the edge after the address is issued
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse; results valid from this cycle on
valid  output  1  no duplicate or illegal value found
solved  output  1  valid and no blank cells
err_group  output  2  first failing group type: 00 none, 01 row, 10 col, 11 box
err_index  output  4  index 0..8 of the first failing group

Behaviour:
- Reset (restart=0 at an edge): state IDLE; all outputs 0; counters and masks cleared. Reset mid-scan aborts the scan; no done pulse; in-flight data is discarded.
- States:
  - IDLE -(start)-> ROWS -> COLS -> BOXES -> FINISH -> IDLE.
  - FINISH lasts one cycle, with done=1 and busy=0.
- Timing: edge E0 samples start=1 in IDLE.
  - Read k (k = 0..242) is issued after edge Ek and sampled at E(k+1).
  - rd_en stays high continuously for 243 cycles.
  - Last sample is at E243; done is high in the cycle after E243.
  - busy is high after E0 through E243.
- Address order: group g = 0..8, element e = 0..8, e fastest.
  - Row: addr = g*9 + e.
  - Col: addr = e*9 + g.
  - Box: row = (g/3)*3 + e/3, col = (g%3)*3 + e%3. Implement with counters, no dividers.
- Per-group 9-bit seen mask, cleared at the start of each group.
  - Value 0 marks the board not-full.
  - Value 1..9 whose bit is already set is a conflict.
  - Value 10..15 is a conflict (illegal).
- First conflict in scan order latches err_group/err_index. Later conflicts do not overwrite it.
- At FINISH:
  - valid = no conflict.
  - solved = valid and no blank seen.
- valid, solved, err_group and err_index hold until the next accepted start, which clears them to 0 at E0.
- start while busy or in FINISH is ignored. start held high re-triggers only once back in IDLE.
- rd_addr holds its last value when rd_en=0.

Optional Feature:
BOARD_CHECK_EARLY_EXIT_EN:
- Defined: when a conflict is sampled at edge Ek, no further read is issued after Ek (rd_en=0). The FSM goes straight to FINISH, and done is high in the cycle after Ek with valid=0, solved=0. Blanks seen before the conflict are irrelevant.
- Undefined: the full 243-read scan always runs, and done comes after E243 regardless of conflicts.

Test Plan:
1. Valid complete board, start pulse -> rd_en high exactly 243 cycles, addresses 0..80, then column order, then box order; done after E243; valid=1, solved=1, err_group=00.
2. Same board with cell (4,4) = 0 -> done after E243; valid=1, solved=0, err_group=00.
3. Valid board with cells (2,0) and (2,4) both 5 -> valid=0, solved=0, err_group=01, err_index=2. Without the macro, done after E243. With BOARD_CHECK_EARLY_EXIT_EN, read 22 is sampled at E23 and done is high in the cycle after E23; rd_en=0 after E23.
4. Cell (0,0) = 12 on an otherwise valid board -> valid=0, err_group=01, err_index=0.
5. restart=0 asserted at E100 mid-scan -> all outputs 0 next cycle, no done pulse. A new start afterwards completes normally with results per scenario 1.
6. start pulsed again at E50 during a scan -> ignored; a single done after E243; rd_addr sequence unchanged.
